// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FPU issue controller.
//   fpu_state_e   - controller state encoding
//   FADD..FNEG    - FPU cluster unit indices (bit position in fpu_in_valid)
//   N_UNITS_DEF   - default number of FPU units
//   CNT_W         - width of the response timeout counter
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } fpu_state_e;

    localparam logic [3:0] FADD  = 4'd0;
    localparam logic [3:0] FSUB  = 4'd1;
    localparam logic [3:0] FMUL  = 4'd2;
    localparam logic [3:0] FDIV  = 4'd3;
    localparam logic [3:0] FSQRT = 4'd4;
    localparam logic [3:0] FTOI  = 4'd5;
    localparam logic [3:0] ITOF  = 4'd6;
    localparam logic [3:0] FEQ   = 4'd7;
    localparam logic [3:0] FLT   = 4'd8;
    localparam logic [3:0] FNEG  = 4'd9;

    localparam int N_UNITS_DEF = 10;
    localparam int CNT_W       = 16;

endpackage

// File: rtl/fpu_timeout_cnt.sv
// fpu_timeout_cnt: 16-bit saturating up-counter with clear/enable and an
// expired flag.
//   clk, rstn  - clock, asynchronous active-low reset
//   clear_i    - synchronous clear to 0 (wins over en_i)
//   en_i       - count one cycle
//   expired_o  - this enabled cycle brings the count to TIMEOUT
module fpu_timeout_cnt
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    // Saturate instead of wrapping so a long stall can never alias back to
    // a small count.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_inc;
        end
    end

    // Compare the post-increment value so the flag fires on the cycle in
    // which the count reaches TIMEOUT, i.e. after exactly TIMEOUT enabled
    // cycles.
    assign expired_o = en_i && !clear_i && (cnt_inc == LIMIT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issues one floating-point op at a time from decode to the
// FPU cluster and returns the result (or an error) with its tag.
//   clk, rstn                         - clock, asynchronous active-low reset
//   req_valid/req_ready               - decode request handshake
//   req_unit, req_a, req_b, req_tag   - unit index, operands, tag
//   rsp_valid/rsp_ready               - response handshake to decode
//   rsp_data, rsp_tag, rsp_err        - result, tag, timeout/illegal-unit flag
//   fpu_data_a/b/c, fpu_in_valid      - operands, tag and one-hot start pulse
//   fpu_out, fpu_out_valid            - FPU result and strobe
//   busy                              - controller not idle
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for a request; req_ready high
// ST_ISSUE | one-cycle fpu_in_valid pulse; timeout counter cleared
// ST_WAIT  | waiting for fpu_out_valid or timeout
// ST_RESP  | rsp_valid high until decode takes it with rsp_ready
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int N_UNITS = N_UNITS_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_unit,
    input  logic [31:0]        req_a,
    input  logic [31:0]        req_b,
    input  logic [7:0]         req_tag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_data,
    output logic [7:0]         rsp_tag,
    output logic               rsp_err,
    output logic [31:0]        fpu_data_a,
    output logic [31:0]        fpu_data_b,
    output logic [7:0]         fpu_data_c,
    output logic [N_UNITS-1:0] fpu_in_valid,
    input  logic [31:0]        fpu_out,
    input  logic               fpu_out_valid,
    output logic               busy
);

    fpu_state_e         state_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [7:0]         tag_q;
    logic [31:0]        rsp_data_q;
    logic               rsp_err_q;
    logic               rsp_valid_q;
    logic               req_ready_q;
    logic               busy_q;
    logic [N_UNITS-1:0] in_valid_q;
    logic               tmo_expired;
    logic               unit_legal;

    assign unit_legal = int'(req_unit) < N_UNITS;

    fpu_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk       (clk),
        .rstn      (rstn),
        .clear_i   (state_q == ST_ISSUE),
        .en_i      (state_q == ST_WAIT),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            in_valid_q  <= '0;
        end else begin
            in_valid_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_q         <= req_a;
                        b_q         <= req_b;
                        tag_q       <= req_tag;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (unit_legal) begin
                            // Pulse is registered here so it lines up with ISSUE.
                            in_valid_q <= N_UNITS'(1) << req_unit;
                            state_q    <= ST_ISSUE;
                        end else begin
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A result arriving on the timeout cycle still wins.
                    if (fpu_out_valid) begin
                        rsp_data_q  <= fpu_out;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (tmo_expired) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign busy         = busy_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_tag      = tag_q;
    assign fpu_data_a   = a_q;
    assign fpu_data_b   = b_q;
    assign fpu_data_c   = tag_q;
    assign fpu_in_valid = in_valid_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

    localparam int NU = 10;
    localparam int TO = 8;

    logic          clk;
    logic          rstn;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_unit;
    logic [31:0]   req_a;
    logic [31:0]   req_b;
    logic [7:0]    req_tag;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic [7:0]    rsp_tag;
    logic          rsp_err;
    logic [31:0]   fpu_data_a;
    logic [31:0]   fpu_data_b;
    logic [7:0]    fpu_data_c;
    logic [NU-1:0] fpu_in_valid;
    logic [31:0]   fpu_out;
    logic          fpu_out_valid;
    logic          busy;

    fpu_issue_ctrl #(
        .N_UNITS (NU),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_unit      (req_unit),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_tag       (req_tag),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_tag       (rsp_tag),
        .rsp_err       (rsp_err),
        .fpu_data_a    (fpu_data_a),
        .fpu_data_b    (fpu_data_b),
        .fpu_data_c    (fpu_data_c),
        .fpu_in_valid  (fpu_in_valid),
        .fpu_out       (fpu_out),
        .fpu_out_valid (fpu_out_valid),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(posedge clk) cyc++;
    always @(negedge clk) if (fpu_in_valid != '0) pulse_cnt++;

    // Transaction-level model: one op in flight, tracked as
    // "pulse due / waited N cycles / response pending".
    logic          m_busy, m_waiting, m_rsp, m_err;
    logic [NU-1:0] m_pulse;
    int            m_waited;
    logic [31:0]   m_a, m_b, m_data;
    logic [7:0]    m_tag;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy = 0; m_waiting = 0; m_rsp = 0; m_err = 0; m_pulse = '0;
            m_waited = 0; m_a = 0; m_b = 0; m_data = 0; m_tag = 0;
        end else if (m_pulse != '0) begin
            m_pulse = '0; m_waiting = 1; m_waited = 0;
        end else if (m_waiting) begin
            m_waited++;
            if (fpu_out_valid) begin
                m_waiting = 0; m_rsp = 1; m_data = fpu_out; m_err = 0;
            end else if (m_waited == TO) begin
                m_waiting = 0; m_rsp = 1; m_data = 0; m_err = 1;
            end
        end else if (m_rsp) begin
            if (rsp_ready) begin m_rsp = 0; m_busy = 0; end
        end else if (req_valid) begin
            m_busy = 1; m_a = req_a; m_b = req_b; m_tag = req_tag;
            if (int'(req_unit) < NU) m_pulse = NU'(1) << req_unit;
            else begin m_rsp = 1; m_err = 1; m_data = 0; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_req_ready", req_ready, !m_busy);
            chk("m_busy", busy, m_busy);
            chk("m_rsp_valid", rsp_valid, m_rsp);
            chk("m_in_valid", fpu_in_valid, m_pulse);
            if (m_busy) begin
                chk("m_data_a", fpu_data_a, m_a);
                chk("m_data_b", fpu_data_b, m_b);
                chk("m_data_c", fpu_data_c, m_tag);
            end
            if (m_rsp) begin
                chk("m_rsp_data", rsp_data, m_data);
                chk("m_rsp_tag", rsp_tag, m_tag);
                chk("m_rsp_err", rsp_err, m_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] u, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] t);
        req_valid = 1; req_unit = u; req_a = a; req_b = b; req_tag = t;
        tick();
        req_valid = 0;
    endtask

    // Op whose result arrives lat cycles after the issue pulse; rsp_ready=1.
    task automatic do_op(input logic [3:0] u, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] t, input int lat, input logic [31:0] res);
        int p0;
        p0 = pulse_cnt;
        send(u, a, b, t);
        repeat (lat) tick();
        fpu_out_valid = 1; fpu_out = res;
        tick();
        fpu_out_valid = 0;
        chk("op_rsp_valid", rsp_valid, 1);
        chk("op_rsp_data", rsp_data, res);
        chk("op_rsp_tag", rsp_tag, t);
        chk("op_rsp_err", rsp_err, 0);
        tick();
        chk("op_idle", req_ready, 1);
        chk("op_pulses", pulse_cnt - p0, 1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int n;
        rstn = 0; req_valid = 0; req_unit = 0; req_a = 0; req_b = 0; req_tag = 0;
        rsp_ready = 1; fpu_out = 0; fpu_out_valid = 0;
        tick();
        chk_en = 1;
        tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_in_valid", fpu_in_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_data_a", fpu_data_a, 0);
        rstn = 1;
        tick();

        // Normal op: FMUL, result three cycles after the pulse.
        p0 = pulse_cnt;
        send(4'd2, 32'h3F80_0000, 32'h4000_0000, 8'h05);
        chk("norm_pulse", fpu_in_valid, 10'b0000000100);
        chk("norm_req_ready", req_ready, 0);
        tick();
        chk("norm_pulse_once", fpu_in_valid, 0);
        tick(); tick();
        fpu_out_valid = 1; fpu_out = 32'h4000_0000;
        tick();
        fpu_out_valid = 0;
        chk("norm_rsp_valid", rsp_valid, 1);
        chk("norm_rsp_data", rsp_data, 32'h4000_0000);
        chk("norm_rsp_tag", rsp_tag, 8'h05);
        chk("norm_rsp_err", rsp_err, 0);
        tick();
        chk("norm_idle", busy, 0);
        chk("norm_pulses", pulse_cnt - p0, 1);

        // Illegal unit index.
        p0 = pulse_cnt;
        send(4'd12, 32'h1111_1111, 32'h2222_2222, 8'h3C);
        chk("ill_rsp_valid", rsp_valid, 1);
        chk("ill_rsp_err", rsp_err, 1);
        chk("ill_rsp_data", rsp_data, 0);
        chk("ill_rsp_tag", rsp_tag, 8'h3C);
        tick();
        chk("ill_idle", busy, 0);
        chk("ill_no_pulse", pulse_cnt - p0, 0);

        // Timeout with no FPU answer, then late results ignored.
        rsp_ready = 0;
        p0 = pulse_cnt;
        send(4'd4, 32'h1, 32'h2, 8'h77);
        chk("tmo_pulse", fpu_in_valid, 10'b0000010000);
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        chk("tmo_wait_cycles", n - 1, TO);
        chk("tmo_err", rsp_err, 1);
        chk("tmo_data", rsp_data, 0);
        fpu_out_valid = 1; fpu_out = 32'hDEAD_BEEF;
        tick();
        fpu_out_valid = 0;
        chk("late_resp_data", rsp_data, 0);
        chk("late_resp_err", rsp_err, 1);
        rsp_ready = 1;
        tick();
        fpu_out_valid = 1; fpu_out = 32'hDEAD_BEEF;
        tick();
        fpu_out_valid = 0;
        chk("late_idle_data", rsp_data, 0);
        chk("late_idle_busy", busy, 0);
        chk("tmo_pulses", pulse_cnt - p0, 1);

        // Backpressure: response held 5 cycles while a new request waits.
        rsp_ready = 0;
        p0 = pulse_cnt;
        send(4'd3, 32'hA, 32'hB, 8'h21);
        tick();
        fpu_out_valid = 1; fpu_out = 32'h1234_5678;
        tick();
        fpu_out_valid = 0;
        req_valid = 1; req_unit = 4'd0; req_a = 32'h55; req_b = 32'h66; req_tag = 8'h22;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 32'h1234_5678);
            chk("bp_rsp_tag", rsp_tag, 8'h21);
            chk("bp_req_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1;
        tick();
        chk("bp_back_idle", req_ready, 1);
        chk("bp_not_issued", pulse_cnt - p0, 1);
        tick();
        req_valid = 0;
        chk("bp_new_pulse", fpu_in_valid, 10'b0000000001);
        chk("bp_new_tag", fpu_data_c, 8'h22);
        tick();
        fpu_out_valid = 1; fpu_out = 32'h0BAD_0BAD;
        tick();
        fpu_out_valid = 0;
        chk("bp_new_data", rsp_data, 32'h0BAD_0BAD);
        tick();

        // Result on the same cycle as the timeout: result wins.
        send(4'd7, 32'h7, 32'h8, 8'h5A);
        repeat (TO) tick();
        fpu_out_valid = 1; fpu_out = 32'hCAFE_F00D;
        tick();
        fpu_out_valid = 0;
        chk("sim_rsp_valid", rsp_valid, 1);
        chk("sim_err", rsp_err, 0);
        chk("sim_data", rsp_data, 32'hCAFE_F00D);
        tick();

        // Reset during WAIT, then a normal op.
        send(4'd1, 32'h9999_0000, 32'h0000_9999, 8'h13);
        tick(); tick();
        rstn = 0;
        #1;
        chk("rmid_busy", busy, 0);
        chk("rmid_req_ready", req_ready, 1);
        chk("rmid_in_valid", fpu_in_valid, 0);
        chk("rmid_data_a", fpu_data_a, 0);
        chk("rmid_data_c", fpu_data_c, 0);
        chk("rmid_rsp_valid", rsp_valid, 0);
        tick(); tick();
        rstn = 1;
        tick();
        chk("rpost_req_ready", req_ready, 1);
        chk("rpost_busy", busy, 0);
        do_op(4'd9, 32'h3F80_0000, 32'h0, 8'hE1, 2, 32'hBF80_0000);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Sequences one floating-point operation at a time from the decode stage into the external FPU cluster, then returns the result to decode.
- Decode raises a request carrying a unit index, two operands and an 8-bit tag. The block drives fpu_data_a/b/c and a one-hot fpu_in_valid pulse, waits for fpu_out_valid, and hands back the result with the tag.
- Adds a per-operation timeout and rejects illegal unit indices, so a stuck or absent FPU unit cannot hang the core.

Parameters:
- N_UNITS, 10, number of FPU units; width of fpu_in_valid.
- TIMEOUT, 255, cycles to wait for fpu_out_valid before declaring an error; legal range 1..65535.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  decode has an FPU op
- req_ready  out  1  block accepts the request this cycle
- req_unit  in  4  FPU unit index, 0..N_UNITS-1
- req_a  in  32  operand A
- req_b  in  32  operand B
- req_tag  in  8  tag/destination, driven onto fpu_data_c
- rsp_valid  out  1  result available
- rsp_ready  in  1  decode consumes the result
- rsp_data  out  32  result word
- rsp_tag  out  8  tag of the completed op
- rsp_err  out  1  1 = timeout or illegal unit; rsp_data is 0
- fpu_data_a  out  32  operand A to the FPU
- fpu_data_b  out  32  operand B to the FPU
- fpu_data_c  out  8  tag to the FPU
- fpu_in_valid  out  N_UNITS  one-hot start pulse
- fpu_out  in  32  FPU result
- fpu_out_valid  in  1  FPU result strobe
- busy  out  1  state != IDLE

Behaviour:
- Reset (rstn low, asynchronous, any state):
  - State goes to IDLE.
  - All outputs are 0 except req_ready, which is 1.
  - Timeout counter is 0.
  - Reset asserted mid-operation abandons the op; no response is produced.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch req_a, req_b, req_tag and req_unit.
  - If req_unit < N_UNITS, go to ISSUE.
  - Otherwise go to RESP with rsp_err=1 and rsp_data=0; no FPU pulse is issued.
- ISSUE, exactly one cycle:
  - fpu_in_valid = (1 << unit) for this single cycle.
  - fpu_data_a/b/c hold the latched values; they stay stable from ISSUE until the response is accepted.
  - Counter clears. Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On fpu_out_valid, latch fpu_out into rsp_data, set rsp_err=0, go to RESP.
  - If the counter reaches TIMEOUT with no fpu_out_valid, go to RESP with rsp_err=1 and rsp_data=0.
  - If fpu_out_valid and timeout occur in the same cycle, the result wins (rsp_err=0).
- RESP:
  - rsp_valid = 1; rsp_data, rsp_tag and rsp_err are stable.
  - On rsp_ready, go to IDLE.
  - rsp_valid rises on the cycle after the result latch.
- Latency:
  - Request accept to fpu_in_valid pulse: 1 cycle.
  - fpu_out_valid to rsp_valid: 1 cycle.
  - Back-to-back minimum is 4 cycles per op (IDLE, ISSUE, WAIT with immediate valid, RESP with rsp_ready=1).
- Other boundary rules:
  - req_ready = 0 in every state except IDLE; requests are not queued.
  - fpu_out_valid outside WAIT (a stray or late result after a timeout) is ignored; state and rsp_* are unchanged.
  - rsp_ready held at 1 while IDLE has no effect.
- Counter:
  - Width is 16 bits; it saturates and never wraps.
  - Comparison is unsigned and equality-based against TIMEOUT.

Decomposition:
- Shared package fpu_pkg holds:
  - State enum: IDLE, ISSUE, WAIT, RESP.
  - FPU unit index constants (FADD=0, FSUB=1, FMUL=2, FDIV=3, FSQRT=4, FTOI=5, ITOF=6, FEQ=7, FLT=8, FNEG=9).
  - N_UNITS default.
- One sub-module, fpu_timeout_cnt: a clear/enable saturating 16-bit counter with an expired flag. Everything else lives in fpu_issue_ctrl.

Test Plan:
- Normal op:
  - Stimulus: req unit=2, a=0x3F800000, b=0x40000000, tag=0x05. FPU returns 0x40000000 three cycles after the pulse; rsp_ready=1.
  - Expected: fpu_in_valid=10'b0000000100 for exactly 1 cycle; rsp_valid with data 0x40000000, tag 0x05, err=0; back in IDLE.
- Illegal unit:
  - Stimulus: req_unit=12.
  - Expected: no fpu_in_valid pulse; rsp_valid with err=1, data=0, matching tag.
- Timeout:
  - Stimulus: TIMEOUT=8; FPU never responds.
  - Expected: rsp_err=1 exactly 8 WAIT cycles after ISSUE. A late fpu_out_valid (0xDEADBEEF) while in RESP/IDLE leaves rsp_data=0.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles after the result.
  - Expected: rsp_* stable, req_ready=0, and a new req_valid is not accepted until the cycle after rsp_ready=1.
- Simultaneous events:
  - Stimulus: fpu_out_valid arrives on the timeout cycle.
  - Expected: err=0, data captured.
- Reset mid-op:
  - Stimulus: drop rstn during WAIT.
  - Expected: outputs clear immediately (asynchronous); after release req_ready=1 and busy=0; a following op completes normally.
